// File: rtl/uart_pkg.sv
// Shared UART definitions: frame phase encoding and data-width limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_PHASE_W       = 3;
    localparam int UART_MIN_DATA_BITS = 5;

    typedef enum logic [UART_PHASE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } phase_e;

    // True when a requested data width lies inside the supported window.
    function automatic logic data_bits_legal(input logic [3:0] bits, input int max_bits);
        return (int'(bits) >= UART_MIN_DATA_BITS) && (int'(bits) <= max_bits);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud prescaler plus oversample counter producing tick, mid-bit and bit-end strobes.
// Latency: strobes are combinational decodes of the registered counters (0 cycles).
// Backpressure: none; enable_i gates counting, clear_i zeroes both counters.
//
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i synchronous clear
// (wins over enable_i); enable_i advances the prescaler; div_i divisor D (tick every
// D+1 clocks); tick_o prescaler wrap; sample_o mid-bit strobe; bit_end_o last tick of a bit.
module uart_baud_tick #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             sample_o,
    output logic             bit_end_o
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0] presc_q;
    logic [OS_W-1:0]  os_q;
    logic             presc_wrap;

    // Equality compare with an explicit wrap to 0, so an all-ones divisor never overflows.
    assign presc_wrap = (presc_q == div_i);
    assign tick_o     = enable_i & presc_wrap;
    assign sample_o   = tick_o & (os_q == OS_MID);
    assign bit_end_o  = tick_o & (os_q == OS_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            os_q    <= '0;
        end else if (clear_i) begin
            presc_q <= '0;
            os_q    <= '0;
        end else if (enable_i) begin
            if (presc_wrap) begin
                presc_q <= '0;
                os_q    <= (os_q == OS_LAST) ? '0 : os_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_bit_sequencer.sv
// UART frame sequencer: walks start, data, optional parity and stop bits on baud ticks.
// Latency: start accepted in cycle 0 -> START in cycle 1; done_o one cycle after last bit_end.
// Backpressure: none; start_i is ignored while busy, abort_i returns to IDLE next cycle.
//
// Ports: clk_i/rst_ni clock and async active-low reset; baud_div_i divisor D;
// data_bits_i data width N (5..MAX_DATA_BITS); parity_en_i parity bit on; stop2_i two
// stop bits; start_i/abort_i control; busy_o, phase_o, bit_idx_o frame position;
// sample_o/bit_end_o bit strobes; done_o frame complete pulse; cfg_err_o rejected start.
module uart_bit_sequencer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int DIV_W         = 16,
    parameter int MAX_DATA_BITS = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DIV_W-1:0]        baud_div_i,
    input  logic [3:0]              data_bits_i,
    input  logic                    parity_en_i,
    input  logic                    stop2_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic [UART_PHASE_W-1:0] phase_o,
    output logic [3:0]              bit_idx_o,
    output logic                    sample_o,
    output logic                    bit_end_o,
    output logic                    done_o,
    output logic                    cfg_err_o
);

    phase_e           phase_q, phase_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;
    logic             accept;

    // Frame configuration captured on an accepted start.
    logic [DIV_W-1:0] div_q;
    logic [3:0]       nbits_q;
    logic             par_q;
    logic             stop2_q;

    logic             tick;
    logic             sample;
    logic             bit_end;
    logic             step;
    logic             idle;
    logic             data_last;
    logic             stop_last;

    assign idle = (phase_q == IDLE);

    // Counters are held at zero in IDLE so a new frame always starts from a clean bit.
    uart_baud_tick #(
        .OVERSAMPLE (OVERSAMPLE),
        .DIV_W      (DIV_W)
    ) u_baud_tick (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (abort_i | idle),
        .enable_i   (~idle),
        .div_i      (div_q),
        .tick_o     (tick),
        .sample_o   (sample),
        .bit_end_o  (bit_end)
    );

    // bit_end already implies a tick; spelled out so the advance condition reads directly.
    assign step      = tick & bit_end;
    assign data_last = (bit_idx_q == nbits_q - 4'd1);
    assign stop_last = ~stop2_q | (bit_idx_q == 4'd1);

    always_comb begin
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        accept    = 1'b0;

        if (abort_i) begin
            phase_d   = IDLE;
            bit_idx_d = '0;
        end else begin
            case (phase_q)
                IDLE: begin
                    bit_idx_d = '0;
                    if (start_i) begin
                        if (data_bits_legal(data_bits_i, MAX_DATA_BITS)) begin
                            accept  = 1'b1;
                            phase_d = START;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                START: begin
                    if (step) begin
                        phase_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    if (step) begin
                        if (data_last) begin
                            phase_d   = par_q ? PARITY : STOP;
                            bit_idx_d = '0;
                        end else begin
                            bit_idx_d = bit_idx_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (step) begin
                        phase_d   = STOP;
                        bit_idx_d = '0;
                    end
                end
                STOP: begin
                    if (step) begin
                        if (stop_last) begin
                            phase_d   = IDLE;
                            bit_idx_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            bit_idx_d = bit_idx_q + 4'd1;
                        end
                    end
                end
                default: begin
                    phase_d   = IDLE;
                    bit_idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q   <= IDLE;
            bit_idx_q <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            nbits_q <= '0;
            par_q   <= 1'b0;
            stop2_q <= 1'b0;
        end else if (accept) begin
            div_q   <= baud_div_i;
            nbits_q <= data_bits_i;
            par_q   <= parity_en_i;
            stop2_q <= stop2_i;
        end
    end

    assign busy_o    = ~idle;
    assign phase_o   = phase_q;
    assign bit_idx_o = bit_idx_q;
    assign sample_o  = sample;
    assign bit_end_o = bit_end;
    assign done_o    = done_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_uart_bit_sequencer.sv
// Directed bench for uart_bit_sequencer: frame timing, config latching, errors, abort, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_bit_sequencer;

    localparam int OS   = 16;
    localparam int DW   = 16;
    localparam int MAXB = 9;

    logic          clk;
    logic          rst_ni;
    logic [DW-1:0] baud_div_i;
    logic [3:0]    data_bits_i;
    logic          parity_en_i;
    logic          stop2_i;
    logic          start_i;
    logic          abort_i;
    logic          busy_o;
    logic [2:0]    phase_o;
    logic [3:0]    bit_idx_o;
    logic          sample_o;
    logic          bit_end_o;
    logic          done_o;
    logic          cfg_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-frame statistics filled in by run_frame.
    int trace_errs, cyc_done, n_samp, n_bend, par_first, par_last;

    uart_bit_sequencer #(
        .OVERSAMPLE    (OS),
        .DIV_W         (DW),
        .MAX_DATA_BITS (MAXB)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .baud_div_i  (baud_div_i),
        .data_bits_i (data_bits_i),
        .parity_en_i (parity_en_i),
        .stop2_i     (stop2_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .phase_o     (phase_o),
        .bit_idx_o   (bit_idx_o),
        .sample_o    (sample_o),
        .bit_end_o   (bit_end_o),
        .done_o      (done_o),
        .cfg_err_o   (cfg_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a start request; the current cycle becomes cycle 0 of the frame.
    task automatic start_frame(input int d, input int n, input int p, input int s2);
        baud_div_i  = d[DW-1:0];
        data_bits_i = n[3:0];
        parity_en_i = p[0];
        stop2_i     = s2[0];
        start_i     = 1'b1;
        abort_i     = 1'b0;
    endtask

    // Walks cycles 1..F*L+1 of a frame started in the current cycle, comparing every
    // output against the closed-form frame timeline. Inputs are scrambled from cycle 1
    // on to show the latched configuration is used. With hold set, start_i stays high
    // and the next frame's configuration is presented so it is accepted at the done cycle.
    task automatic run_frame(input string tag, input int d, input int n, input int p, input int s2,
                             input bit hold, input int nd, input int nn, input int np, input int ns2);
        int f, l, last, b, k, e_ph, e_idx;
        bit tk, e_smp, e_be, e_done, e_busy;
        f    = 1 + n + p + (s2 != 0 ? 2 : 1);
        l    = OS * (d + 1);
        last = f * l;
        trace_errs = 0; cyc_done = -1; n_samp = 0; n_bend = 0; par_first = -1; par_last = -1;
        for (int c = 1; c <= last + 1; c++) begin
            next_cycle();
            if (c == 1) begin
                start_i     = hold;
                baud_div_i  = 16'(d + 5);
                data_bits_i = (n == 9) ? 4'd5 : 4'd9;
                parity_en_i = ~p[0];
                stop2_i     = ~s2[0];
            end
            if (c <= last) begin
                b      = (c - 1) / l;
                tk     = (c % (d + 1)) == 0;
                k      = c / (d + 1);
                e_smp  = tk && (((k - 1) % OS) == OS / 2 - 1);
                e_be   = tk && (((k - 1) % OS) == OS - 1);
                e_busy = 1'b1;
                e_done = 1'b0;
                if (b == 0) begin
                    e_ph = 1; e_idx = 0;
                end else if (b <= n) begin
                    e_ph = 2; e_idx = b - 1;
                end else if (p != 0 && b == n + 1) begin
                    e_ph = 3; e_idx = 0;
                end else begin
                    e_ph = 4; e_idx = b - 1 - n - p;
                end
            end else begin
                e_ph = 0; e_idx = 0; e_smp = 1'b0; e_be = 1'b0; e_busy = 1'b0; e_done = 1'b1;
            end
            if (phase_o !== e_ph[2:0] || bit_idx_o !== e_idx[3:0] || sample_o !== e_smp ||
                bit_end_o !== e_be || done_o !== e_done || busy_o !== e_busy || cfg_err_o !== 1'b0)
                trace_errs++;
            if (sample_o === 1'b1) n_samp++;
            if (bit_end_o === 1'b1) n_bend++;
            if (done_o === 1'b1 && cyc_done < 0) cyc_done = c;
            if (phase_o === 3'd3) begin
                if (par_first < 0) par_first = c;
                par_last = c;
            end
            if (hold && c == last) start_frame(nd, nn, np, ns2);
        end
        check_eq({tag, "_trace_errs"}, trace_errs, 0);
        check_eq({tag, "_done_cycle"}, cyc_done, last + 1);
        check_eq({tag, "_samples"}, n_samp, f);
        check_eq({tag, "_bit_ends"}, n_bend, f);
    endtask

    // Start with an illegal width: one cfg_err_o pulse, never busy, no strobes.
    task automatic cfg_err_case(input string tag, input logic [3:0] bits);
        int noise;
        start_frame(0, 8, 0, 0);
        data_bits_i = bits;
        next_cycle();
        start_i = 1'b0;
        check_eq({tag, "_cfg_err"}, cfg_err_o, 1);
        check_eq({tag, "_busy"}, busy_o, 0);
        check_eq({tag, "_phase"}, phase_o, 0);
        noise = 0;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            if (cfg_err_o !== 1'b0 || busy_o !== 1'b0 || sample_o !== 1'b0 || bit_end_o !== 1'b0)
                noise++;
        end
        check_eq({tag, "_quiet_after"}, noise, 0);
    endtask

    initial begin
        int noise;
        rst_ni      = 1'b0;
        baud_div_i  = '0;
        data_bits_i = 4'd8;
        parity_en_i = 1'b0;
        stop2_i     = 1'b0;
        start_i     = 1'b0;
        abort_i     = 1'b0;

        // Reset state, both during reset and just after release.
        #12;
        check_eq("rst_phase", phase_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_strobes", {sample_o, bit_end_o, done_o, cfg_err_o}, 0);
        check_eq("rst_bit_idx", bit_idx_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        next_cycle();
        check_eq("idle_phase", phase_o, 0);
        check_eq("idle_busy", busy_o, 0);

        // 8N1, D=0: samples 8..152, bit ends 16..160, done at 161.
        start_frame(0, 8, 0, 0);
        run_frame("t1_8n1_d0", 0, 8, 0, 0, 1'b0, 0, 0, 0, 0);
        check_eq("t1_done_at_161", cyc_done, 161);

        // Illegal widths just below and just above the legal window.
        next_cycle();
        cfg_err_case("t3_bits4", 4'd4);
        cfg_err_case("t3_bits10", 4'd10);

        // Abort during DATA bit 3 (cycles 65..80 for 8N1, D=0).
        start_frame(0, 8, 0, 0);
        for (int c = 1; c <= 70; c++) begin
            next_cycle();
            if (c == 1) start_i = 1'b0;
        end
        check_eq("t4_pre_abort_phase", phase_o, 2);
        check_eq("t4_pre_abort_idx", bit_idx_o, 3);
        abort_i = 1'b1;
        next_cycle();
        abort_i = 1'b0;
        check_eq("t4_abort_phase", phase_o, 0);
        check_eq("t4_abort_busy", busy_o, 0);
        check_eq("t4_abort_idx", bit_idx_o, 0);
        noise = 0;
        for (int c = 0; c < 200; c++) begin
            next_cycle();
            if (done_o !== 1'b0 || busy_o !== 1'b0) noise++;
        end
        check_eq("t4_no_done_after_abort", noise, 0);

        // start_i and abort_i together in IDLE: abort wins.
        start_frame(0, 8, 0, 0);
        abort_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        abort_i = 1'b0;
        check_eq("t4_sa_phase", phase_o, 0);
        check_eq("t4_sa_busy", busy_o, 0);
        check_eq("t4_sa_cfg_err", cfg_err_o, 0);
        noise = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            if (busy_o !== 1'b0) noise++;
        end
        check_eq("t4_sa_stays_idle", noise, 0);

        // Back-to-back: start held high, second frame (D=1, 7E1) accepted at the done cycle.
        start_frame(0, 8, 0, 0);
        run_frame("t5_first", 0, 8, 0, 0, 1'b1, 1, 7, 1, 0);
        run_frame("t5_second", 1, 7, 1, 0, 1'b0, 0, 0, 0, 0);
        check_eq("t5_second_done_at_321", cyc_done, 321);

        // 9 data bits, parity, 2 stop bits, D=3: F=13, done at 833, parity 641..704.
        next_cycle();
        start_frame(3, 9, 1, 1);
        run_frame("t2_9p2_d3", 3, 9, 1, 1, 1'b0, 0, 0, 0, 0);
        check_eq("t2_done_at_833", cyc_done, 833);
        check_eq("t2_parity_first", par_first, 641);
        check_eq("t2_parity_last", par_last, 704);

        // Asynchronous reset in the middle of STOP.
        next_cycle();
        start_frame(0, 8, 0, 0);
        for (int c = 1; c <= 150; c++) begin
            next_cycle();
            if (c == 1) start_i = 1'b0;
        end
        check_eq("t6_pre_reset_phase", phase_o, 4);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_phase", phase_o, 0);
        check_eq("t6_rst_busy", busy_o, 0);
        check_eq("t6_rst_idx", bit_idx_o, 0);
        check_eq("t6_rst_strobes", {sample_o, bit_end_o, done_o, cfg_err_o}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        noise = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            if (done_o !== 1'b0 || busy_o !== 1'b0) noise++;
        end
        check_eq("t6_no_done_after_reset", noise, 0);
        start_frame(0, 8, 0, 0);
        run_frame("t6_after_reset", 0, 8, 0, 0, 1'b0, 0, 0, 0, 0);
        check_eq("t6_done_at_161", cyc_done, 161);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bit_sequencer.md
Name: uart_bit_sequencer

Overview:
Parametrised successor to the UART single-count bit counter. It combines a baud prescaler, an oversampling counter and a frame bit counter into one sequencer. The sequencer walks a programmable frame: start, 5..MAX_DATA_BITS data bits, optional parity, and 1 or 2 stop bits. It emits mid-bit sample strobes, bit-end strobes and phase/index information, and is shared by the UART TX and RX datapaths.

Parameters:
OVERSAMPLE, 16, ticks per bit; even, at least 4.
DIV_W, 16, width of the baud divisor.
MAX_DATA_BITS, 9, upper legal data_bits_i value; at most 15.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
baud_div_i  in  DIV_W  prescaler divisor D; one tick every D+1 clocks.
data_bits_i  in  4  data bits per frame; legal range 5..MAX_DATA_BITS.
parity_en_i  in  1  1 = insert parity bit.
stop2_i  in  1  0 = one stop bit, 1 = two stop bits.
start_i  in  1  start frame; sampled only in IDLE.
abort_i  in  1  synchronous abort.
busy_o  out  1  high whenever phase is not IDLE.
phase_o  out  3  current phase_e encoding.
bit_idx_o  out  4  index within the current phase (data bit number or stop bit number), 0 otherwise.
sample_o  out  1  mid-bit strobe.
bit_end_o  out  1  last cycle of the current bit.
done_o  out  1  one-cycle pulse after the final stop bit.
cfg_err_o  out  1  one-cycle pulse when a start is rejected because of an illegal data_bits_i.

Behaviour:
- Reset (async assert, sync release): phase IDLE, prescaler, oversample counter and bit counter all 0. busy_o, sample_o, bit_end_o, done_o and cfg_err_o = 0; bit_idx_o = 0; phase_o = IDLE.
- Configuration latching:
  - baud_div_i, data_bits_i, parity_en_i and stop2_i are latched on an accepted start.
  - Input changes during a frame have no effect.
- Start handling:
  - An accepted start is start_i=1, abort_i=0 and phase IDLE in cycle 0.
  - Cycle 1: phase START, all counters 0.
  - start_i while busy is ignored.
  - start_i with data_bits_i outside 5..MAX_DATA_BITS: cfg_err_o=1 in cycle 1, phase stays IDLE.
- Prescaler:
  - Counts 0..D; tick = (presc == D), then presc wraps to 0.
  - D=0 gives a tick every clock.
- Oversample counter:
  - Increments on each tick and wraps at OVERSAMPLE-1.
  - sample_o = tick & (os == OVERSAMPLE/2-1).
  - bit_end_o = tick & (os == OVERSAMPLE-1).
  - Both strobes are combinational decodes of registered state and are forced to 0 in IDLE.
- Phase transitions (all taken on bit_end):
  - START -> DATA.
  - DATA, bit_idx N-1 -> PARITY if parity enabled, else STOP.
  - PARITY -> STOP.
  - STOP, last stop bit -> IDLE, with done_o=1 in the next cycle.
- bit_idx resets to 0 on every phase change.
- Timing, with D the latched divisor:
  - k-th tick of a frame occurs at cycle k*(D+1).
  - Each bit lasts OVERSAMPLE*(D+1) clocks.
  - Frame length F = 1 + N + P + S bits; last bit_end at cycle F*OVERSAMPLE*(D+1).
  - done_o and phase IDLE both appear in cycle F*OVERSAMPLE*(D+1)+1.
  - A new start is accepted in that same cycle, with no dead cycle.
- Abort: abort_i=1 in any phase returns to IDLE next cycle with all counters cleared and no done_o. Simultaneous start_i and abort_i in IDLE: abort wins.
- Reset asserted mid-frame: immediate return to reset values. No done_o is produced.
- Widths: the prescaler is DIV_W bits and the oversample counter is $clog2(OVERSAMPLE) bits. The compare against D is unsigned, so D at its all-ones maximum must not overflow.

Decomposition:
- Shared package uart_pkg holds:
  - phase_e enum, 3 bits: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - Constants UART_MIN_DATA_BITS=5 and UART_PHASE_W=3.
- One natural sub-module, uart_baud_tick. It contains the prescaler plus the oversample counter, with clear and enable inputs. It outputs tick, sample and bit_end, and is reusable by the RX edge detector.

Test Plan:
1. 8N1, D=0, OVERSAMPLE=16, start at cycle 0 -> sample_o at cycles 8, 24, ..., 152; bit_end_o at 16, 32, ..., 160; done_o at cycle 161 only; bit_idx_o 0..7 during DATA.
2. 9-bit, parity on, 2 stop, D=3 -> F=13, done_o at cycle 13*16*4+1=833; PARITY phase spans cycles 641..704.
3. data_bits_i=4 and, separately, 10, with start -> cfg_err_o pulse at cycle 1, busy_o stays 0, no strobes.
4. abort_i in DATA at bit_idx 3, and start_i+abort_i together in IDLE -> IDLE next cycle, no done_o; start ignored.
5. Back-to-back: start_i held high across done -> second frame START at the done_o cycle; baud_div_i changed mid-frame has no effect until the next start.
6. rst_ni pulsed low asynchronously mid-STOP -> all outputs 0 immediately; first start after release gives the same timing as scenario 1.
